// File: rtl/conv_layer_mc.sv
// Multi-channel KxK stride-1 "valid" convolution over a raster-order pixel stream.
// Pipeline: window (p0), products (p1), channel sums (p2), scale/bias/saturate/ReLU into outputs.
module conv_layer_mc #(
    parameter int DW     = 12,
    parameter int WW     = 8,
    parameter int CIN    = 3,
    parameter int COUT   = 3,
    parameter int K      = 5,
    parameter int WIDTH  = 12,
    parameter int HEIGHT = 12,
    parameter int SHIFT  = 1,
    localparam int NT    = CIN * K * K,
    localparam int ACCW  = DW + WW + $clog2(NT),
    localparam int AW    = $clog2(COUT * NT + COUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   relu_en,
    input  logic                   in_valid,
    input  logic [CIN*DW-1:0]      in_data,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic signed [WW-1:0]   cfg_data,
    output logic                   out_valid,
    output logic [COUT*DW-1:0]     out_data,
    output logic [COUT-1:0]        sat_flag,
    output logic                   frame_done
);

    localparam int NCOEF = COUT * NT + COUT;
    localparam int PW    = DW + WW;
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);

    localparam logic signed [ACCW:0]  YMAX = (ACCW+1)'(2 ** (DW - 1) - 1);
    localparam logic signed [ACCW:0]  YMIN = (ACCW+1)'(-(2 ** (DW - 1)));
    localparam logic signed [DW-1:0]  DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]  DMIN = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [WW-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic signed [ACCW-1:0] tree_sum(input logic signed [PW-1:0] p [NT]);
        logic signed [ACCW-1:0] s;
        s = '0;
        for (int t = 0; t < NT; t++) begin
            s = s + ACCW'(p[t]);
        end
        return s;
    endfunction

    function automatic logic signed [ACCW:0] scale_bias(input logic signed [ACCW-1:0] acc,
                                                        input logic signed [WW-1:0]   b);
        return (ACCW+1)'(acc >>> SHIFT) + (ACCW+1)'(b);
    endfunction

    // Returns {saturated, value}; ReLU is applied after the clamp and never touches the flag.
    function automatic logic [DW:0] sat_relu(input logic signed [ACCW:0] y,
                                             input logic               relu);
        logic signed [DW-1:0] v;
        logic                 s;
        if (y > YMAX) begin
            v = DMAX;
            s = 1'b1;
        end else if (y < YMIN) begin
            v = DMIN;
            s = 1'b1;
        end else begin
            v = y[DW-1:0];
            s = 1'b0;
        end
        if (relu && v[DW-1]) begin
            v = '0;
        end
        return {s, v};
    endfunction

    logic signed [WW-1:0] r_coef [NCOEF];
    logic signed [DW-1:0] r_lb [CIN][K-1][WIDTH];
    logic signed [DW-1:0] r_win_p0 [CIN][K][K];
    logic signed [DW-1:0] w_px [CIN];
    logic [DW:0]          w_res [COUT];

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_vld_p0, r_vld_p1, r_vld_p2;
    logic          r_last_p0, r_last_p1, r_last_p2;
    logic          w_col_end, w_row_end;

    assign w_col_end = (r_col == CW'(WIDTH - 1));
    assign w_row_end = (r_row == RW'(HEIGHT - 1));

    always_comb begin
        for (int i = 0; i < CIN; i++) begin
            w_px[i] = in_data[i*DW +: DW];
        end
    end

    // Coefficients survive reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && (int'(cfg_addr) < NCOEF)) begin
            r_coef[cfg_addr] <= cfg_data;
        end
    end

    // Stage p0: line buffers and window shift on each accepted pixel
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < CIN; i++) begin
                for (int j = K - 2; j >= 1; j--) begin
                    r_lb[i][j][r_col] <= r_lb[i][j-1][r_col];
                end
                r_lb[i][0][r_col] <= w_px[i];
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K - 1; kx++) begin
                        r_win_p0[i][ky][kx] <= r_win_p0[i][ky][kx+1];
                    end
                end
                for (int ky = 0; ky < K - 1; ky++) begin
                    r_win_p0[i][ky][K-1] <= r_lb[i][K-2-ky][r_col];
                end
                r_win_p0[i][K-1][K-1] <= w_px[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_last_p1 <= 1'b0;
            r_last_p2 <= 1'b0;
        end else begin
            r_vld_p0  <= in_valid && (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));
            r_last_p0 <= in_valid && w_row_end && w_col_end;
            r_vld_p1  <= r_vld_p0;
            r_last_p1 <= r_last_p0;
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
            if (in_valid) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    for (genvar o = 0; o < COUT; o++) begin : g_oc
        logic signed [PW-1:0]   r_prod_p1 [NT];
        logic signed [ACCW-1:0] r_acc_p2;

        // Stage p1: products; stage p2: sum across all channels and taps
        always_ff @(posedge clk) begin
            for (int i = 0; i < CIN; i++) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        r_prod_p1[(i*K+ky)*K+kx] <=
                            mul(r_win_p0[i][ky][kx], r_coef[o*NT + (i*K+ky)*K + kx]);
                    end
                end
            end
            r_acc_p2 <= tree_sum(r_prod_p1);
        end

        assign w_res[o] = sat_relu(scale_bias(r_acc_p2, r_coef[COUT*NT + o]), relu_en);
    end

    // Stage p3: output registers, held between valid beats
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_data   <= '0;
            sat_flag   <= '0;
        end else begin
            out_valid  <= r_vld_p2;
            frame_done <= r_vld_p2 && r_last_p2;
            if (r_vld_p2) begin
                for (int o = 0; o < COUT; o++) begin
                    out_data[o*DW +: DW] <= w_res[o][DW-1:0];
                    sat_flag[o]          <= w_res[o][DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_mc.sv
// Directed bench for conv_layer_mc: a reference convolution fills a scoreboard queue at
// pixel-drive time and a negedge monitor pops and compares each output beat.
module tb_conv_layer_mc;

    localparam int DW = 12, WW = 8, CIN = 3, COUT = 3, K = 5;
    localparam int WIDTH = 12, HEIGHT = 12, SHIFT = 1;
    localparam int NT = CIN * K * K;
    localparam int AW = $clog2(COUT * NT + COUT);
    localparam int NCOEF = COUT * NT + COUT;

    typedef struct {
        logic [COUT*DW-1:0] data;
        logic [COUT-1:0]    sat;
        logic               done;
        int                 stamp;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 relu_en = 1'b0;
    logic                 in_valid = 1'b0;
    logic [CIN*DW-1:0]    in_data = '0;
    logic                 cfg_we = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic signed [WW-1:0] cfg_data = '0;
    logic                 out_valid;
    logic [COUT*DW-1:0]   out_data;
    logic [COUT-1:0]      sat_flag;
    logic                 frame_done;

    conv_layer_mc #(
        .DW(DW), .WW(WW), .CIN(CIN), .COUT(COUT), .K(K),
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .relu_en(relu_en),
        .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_data(out_data),
        .sat_flag(sat_flag), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int   n_tests = 0, n_fail = 0;
    int   tw [COUT][NT];
    int   tbias [COUT];
    int   img [CIN][HEIGHT][WIDTH];
    exp_t q [$];

    int                 n_out = 0, n_done = 0, first_out = 0, prev_out = 0, gap01 = 0, c0 = 0;
    logic [COUT*DW-1:0] last_data;
    logic [COUT-1:0]    last_sat;
    exp_t               m_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input int r, input int c);
        exp_t   e;
        longint acc, y;
        e.data = '0;
        e.sat  = '0;
        for (int o = 0; o < COUT; o++) begin
            acc = 0;
            for (int i = 0; i < CIN; i++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        acc += longint'(img[i][r-K+1+ky][c-K+1+kx]) * longint'(tw[o][(i*K+ky)*K+kx]);
            y = (acc >>> SHIFT) + longint'(tbias[o]);
            if (y > 2047) begin
                y = 2047;
                e.sat[o] = 1'b1;
            end else if (y < -2048) begin
                y = -2048;
                e.sat[o] = 1'b1;
            end
            if (relu_en && y < 0) y = 0;
            e.data[o*DW +: DW] = DW'(y);
        end
        e.done  = (r == HEIGHT - 1) && (c == WIDTH - 1);
        e.stamp = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid !== 1'b0) begin
            chk("expected_out", q.size() > 0, 1);
            if (q.size() > 0) begin
                m_e = q.pop_front();
                chk("data", out_data, m_e.data);
                chk("sat", sat_flag, m_e.sat);
                chk("frame_done", frame_done, m_e.done);
                chk("latency", ncyc, m_e.stamp);
            end
            if (n_out == 0) first_out = ncyc;
            if (n_out == 1) gap01 = ncyc - prev_out;
            prev_out = ncyc;
            n_out++;
            if (frame_done === 1'b1) n_done++;
            last_data = out_data;
            last_sat  = sat_flag;
        end else begin
            chk("done_idle", frame_done, 0);
        end
    end

    task automatic wr(input int a, input int v);
        @(posedge clk); #2;
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = WW'(v);
        if (a < COUT * NT) tw[a / NT][a % NT] = v;
        else if (a < NCOEF) tbias[a - COUT * NT] = v;
    endtask

    task automatic wr_end();
        @(posedge clk); #2;
        cfg_we = 1'b0;
    endtask

    // mode 0: basic (o=0,i=0 weights 1, bias0=3); 1: small random; 2: all weights 127, bias 0
    task automatic load_cfg(input int mode);
        int v;
        for (int a = 0; a < NCOEF; a++) begin
            if (a < COUT * NT) begin
                case (mode)
                    0: v = ((a / NT == 0) && ((a % NT) / (K * K) == 0)) ? 1 : 0;
                    1: v = int'($urandom_range(0, 14)) - 7;
                    default: v = 127;
                endcase
            end else begin
                case (mode)
                    0: v = (a == COUT * NT) ? 3 : 0;
                    1: v = int'($urandom_range(0, 200)) - 100;
                    default: v = 0;
                endcase
            end
            wr(a, v);
        end
        wr_end();
    endtask

    // mode 0: ch0=2 others 0; 1: random +-31; 2: all 2047; 3: all -2048
    task automatic stream(input int mode, input int npix, input int gap);
        logic [CIN*DW-1:0] d;
        int   r, c, v;
        exp_t e;
        n_out = 0;
        n_done = 0;
        for (int p = 0; p < npix; p++) begin
            r = p / WIDTH;
            c = p % WIDTH;
            @(posedge clk); #2;
            if (p == 0) c0 = ncyc;
            for (int i = 0; i < CIN; i++) begin
                case (mode)
                    0: v = (i == 0) ? 2 : 0;
                    1: v = int'($urandom_range(0, 62)) - 31;
                    2: v = 2047;
                    default: v = -2048;
                endcase
                img[i][r][c] = v;
                d[i*DW +: DW] = DW'(v);
            end
            in_valid = 1'b1;
            in_data  = d;
            if (r >= K - 1 && c >= K - 1) begin
                e = model(r, c);
                e.stamp = ncyc + 4;
                q.push_back(e);
            end
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #2;
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        load_cfg(0);
        stream(0, WIDTH * HEIGHT, 1);
        drain();
        chk("basic_count", n_out, 64);
        chk("basic_done_count", n_done, 1);
        chk("basic_first_cycle", first_out - c0, 56);
        chk("basic_last_cycle", prev_out - c0, 147);
        chk("basic_value", last_data, {12'd0, 12'd0, 12'd28});

        wr(COUT * NT, -5);
        wr(NCOEF, 100);
        wr_end();
        stream(0, WIDTH * HEIGHT, 3);
        drain();
        chk("gap_count", n_out, 64);
        chk("gap_spacing", gap01, 3);
        chk("bias_reload_value", last_data, {12'd0, 12'd0, 12'd20});

        load_cfg(1);
        stream(1, WIDTH * HEIGHT, 1);
        drain();
        relu_en = 1'b1;
        stream(1, WIDTH * HEIGHT, 2);
        drain();
        relu_en = 1'b0;

        load_cfg(2);
        stream(2, WIDTH * HEIGHT, 1);
        drain();
        chk("sat_pos_value", last_data, {3{12'h7FF}});
        chk("sat_pos_flag", last_sat, 3'b111);
        stream(3, WIDTH * HEIGHT, 1);
        drain();
        chk("sat_neg_value", last_data, {3{12'h800}});
        chk("sat_neg_flag", last_sat, 3'b111);
        relu_en = 1'b1;
        stream(3, WIDTH * HEIGHT, 1);
        drain();
        chk("sat_relu_value", last_data, 36'd0);
        chk("sat_relu_flag", last_sat, 3'b111);
        relu_en = 1'b0;

        load_cfg(0);
        stream(0, 60, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        in_valid = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_data = 8'sd9;
        while (q.size() > 0 && q[q.size()-1].stamp > ncyc) void'(q.pop_back());
        @(posedge clk); #2;
        rst = 1'b0;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_sat_flag", sat_flag, 0);
        chk("midrst_frame_done", frame_done, 0);
        repeat (6) @(posedge clk);
        stream(0, WIDTH * HEIGHT, 1);
        drain();
        chk("post_rst_count", n_out, 64);
        chk("post_rst_first_cycle", first_out - c0, 56);
        chk("post_rst_value", last_data, {12'd0, 12'd0, 12'd28});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
